// File: rtl/limb_norm_pkg.sv
// Shared types and sizing helpers for the limb carry normalizer.
package limb_norm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int carry_width(input int bit_len, input int word_len);
      return bit_len - word_len + 1;
   endfunction

   function automatic int num_groups(input int num_limbs, input int limbs_per_cycle);
      return num_limbs / limbs_per_cycle;
   endfunction

endpackage

// File: rtl/limb_carry_slice.sv
// Combinational carry ripple across one group of redundant limbs.
module limb_carry_slice #(
   parameter int L        = 2,
   parameter int BIT_LEN  = 17,
   parameter int WORD_LEN = 16,
   parameter int CARRY_W  = 2
) (
   input  logic [BIT_LEN-1:0]  limbs [L],
   input  logic [CARRY_W-1:0]  carry_in,
   output logic [WORD_LEN-1:0] words [L],
   output logic [CARRY_W-1:0]  carry_out
);

   logic [CARRY_W-1:0] c;
   logic [BIT_LEN:0]   s;

   always_comb begin
      c = carry_in;
      s = '0;
      for (int j = 0; j < L; j++) begin
         s        = {1'b0, limbs[j]} + (BIT_LEN+1)'(c);
         words[j] = s[WORD_LEN-1:0];
         c        = s[BIT_LEN:WORD_LEN];
      end
      carry_out = c;
   end

endmodule

// File: rtl/limb_carry_normalizer.sv
// Captures a redundant-limb product and resolves carries a group of limbs per clock.
module limb_carry_normalizer
   import limb_norm_pkg::*;
#(
   parameter int NUM_LIMBS       = 34,
   parameter int BIT_LEN         = 17,
   parameter int WORD_LEN        = 16,
   parameter int LIMBS_PER_CYCLE = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BIT_LEN-1:0]  in_limbs [NUM_LIMBS],
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WORD_LEN-1:0] out_words [NUM_LIMBS],
   output logic [carry_width(BIT_LEN, WORD_LEN)-1:0] out_carry
);

   // state | meaning
   // IDLE  | waiting for an operand, in_ready high
   // RUN   | resolving group idx, carry held between groups
   // DONE  | result valid and held until out_ready

   localparam int L       = LIMBS_PER_CYCLE;
   localparam int CARRY_W = carry_width(BIT_LEN, WORD_LEN);
   localparam int G       = num_groups(NUM_LIMBS, LIMBS_PER_CYCLE);
   localparam int IDX_W   = (G > 1) ? $clog2(G) : 1;
   localparam int AW      = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

   if ((NUM_LIMBS % LIMBS_PER_CYCLE) != 0 || BIT_LEN <= WORD_LEN) begin : g_bad_params
      $error("limb_carry_normalizer: illegal parameter combination");
   end

   state_t             state, state_nx;
   logic [IDX_W-1:0]   idx;
   logic [CARRY_W-1:0] carry;
   logic [BIT_LEN-1:0] work [NUM_LIMBS];
   logic [AW-1:0]      base;
   logic [BIT_LEN-1:0] grp_limbs [L];
   logic [WORD_LEN-1:0] grp_words [L];
   logic [CARRY_W-1:0] grp_carry;
   logic               accept;
   logic               last;

   assign in_ready  = (state == IDLE) && rst_n;
   assign accept    = in_valid && in_ready;
   assign last      = (idx == IDX_W'(G - 1));
   assign out_valid = (state == DONE);
   assign base      = AW'(idx) * AW'(L);

   always_comb begin
      for (int j = 0; j < L; j++) grp_limbs[j] = work[base + AW'(j)];
      for (int i = 0; i < NUM_LIMBS; i++) out_words[i] = work[i][WORD_LEN-1:0];
   end

   limb_carry_slice #(
      .L        (L),
      .BIT_LEN  (BIT_LEN),
      .WORD_LEN (WORD_LEN),
      .CARRY_W  (CARRY_W)
   ) u_slice (
      .limbs     (grp_limbs),
      .carry_in  (carry),
      .words     (grp_words),
      .carry_out (grp_carry)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Resolved words overwrite their limbs in place; the upper bits become zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx       <= '0;
         carry     <= '0;
         out_carry <= '0;
         for (int i = 0; i < NUM_LIMBS; i++) work[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  for (int i = 0; i < NUM_LIMBS; i++) work[i] <= in_limbs[i];
                  idx   <= '0;
                  carry <= '0;
               end
            end
            RUN: begin
               for (int j = 0; j < L; j++)
                  work[base + AW'(j)] <= {{(BIT_LEN-WORD_LEN){1'b0}}, grp_words[j]};
               carry <= grp_carry;
               if (last) begin
                  idx       <= '0;
                  out_carry <= grp_carry;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_limb_carry_normalizer.sv
// Directed bench: default, single-group and single-limb-per-cycle normalizers on shared stimulus.
module tb_limb_carry_normalizer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [16:0] in_limbs [34];

   logic        d_ready, d_valid, w_ready, w_valid, n_ready, n_valid;
   logic [15:0] d_words [34];
   logic [15:0] w_words [34];
   logic [15:0] n_words [34];
   logic [1:0]  d_carry, w_carry, n_carry;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   limb_carry_normalizer u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_ready),
      .in_limbs(in_limbs), .out_valid(d_valid), .out_ready(out_ready),
      .out_words(d_words), .out_carry(d_carry)
   );

   limb_carry_normalizer #(.LIMBS_PER_CYCLE(34)) u_wide (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_ready),
      .in_limbs(in_limbs), .out_valid(w_valid), .out_ready(out_ready),
      .out_words(w_words), .out_carry(w_carry)
   );

   limb_carry_normalizer #(.LIMBS_PER_CYCLE(1)) u_narrow (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_ready),
      .in_limbs(in_limbs), .out_valid(n_valid), .out_ready(out_ready),
      .out_words(n_words), .out_carry(n_carry)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // kind 0: all zero, kind 1: limb0=0x10000, kind 2: all 0x1FFFF
   function automatic logic [15:0] exp_word(input int kind, input int i);
      case (kind)
         1:       return (i == 1) ? 16'h0001 : 16'h0000;
         2:       return (i == 0) ? 16'hFFFF : ((i == 1) ? 16'h0000 : 16'h0001);
         default: return 16'h0000;
      endcase
   endfunction

   task automatic fill(input int kind);
      for (int i = 0; i < 34; i++) begin
         case (kind)
            1:       in_limbs[i] = (i == 0) ? 17'h10000 : 17'h00000;
            2:       in_limbs[i] = 17'h1FFFF;
            default: in_limbs[i] = 17'h00000;
         endcase
      end
   endtask

   task automatic chk_result(input string tag, input int kind, input logic [1:0] exp_c);
      for (int i = 0; i < 34; i++)
         chk($sformatf("%s_w%0d", tag, i), 32'(d_words[i]), 32'(exp_word(kind, i)));
      chk({tag, "_carry"}, 32'(d_carry), 32'(exp_c));
   endtask

   task automatic send(input string tag);
      in_valid = 1'b1;
      chk({tag, "_in_ready"}, 32'(d_ready), 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int exp_lat);
      int n = 0;
      while (!d_valid && n < 100) begin
         step();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
   endtask

   task automatic drain(input string tag);
      step();
      chk({tag, "_drain_valid"}, 32'(d_valid), 32'd0);
      chk({tag, "_drain_in_ready"}, 32'(d_ready), 32'd1);
   endtask

   int          lat_w, lat_n, lat_d;
   logic [15:0] cap_w [34];
   logic [15:0] cap_n [34];
   logic [1:0]  cw, cn;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      fill(0);
      step();
      step();
      chk("rst_out_valid", 32'(d_valid), 32'd0);
      chk("rst_in_ready_low", 32'(d_ready), 32'd0);
      chk("rst_carry", 32'(d_carry), 32'd0);
      chk("rst_word0", 32'(d_words[0]), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready_high", 32'(d_ready), 32'd1);

      // scenario 1: all-zero operand
      fill(0);
      send("s1");
      chk("s1_busy", 32'(d_ready), 32'd0);
      wait_valid("s1", 17);
      chk_result("s1", 0, 2'd0);
      drain("s1");

      // scenario 2: single overflowing bottom limb
      fill(1);
      send("s2");
      wait_valid("s2", 17);
      chk_result("s2", 1, 2'd0);
      drain("s2");

      // scenario 3: all limbs at maximum
      fill(2);
      send("s3");
      wait_valid("s3", 17);
      chk_result("s3", 2, 2'd2);
      drain("s3");

      // scenario 4: backpressure with a pending new operand
      out_ready = 1'b0;
      fill(1);
      send("s4");
      wait_valid("s4", 17);
      fill(2);
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("s4_hold_valid%0d", k), 32'(d_valid), 32'd1);
         chk($sformatf("s4_hold_in_ready%0d", k), 32'(d_ready), 32'd0);
         chk($sformatf("s4_hold_w1_%0d", k), 32'(d_words[1]), 32'h1);
         chk($sformatf("s4_hold_w2_%0d", k), 32'(d_words[2]), 32'h0);
         chk($sformatf("s4_hold_carry%0d", k), 32'(d_carry), 32'd0);
      end
      out_ready = 1'b1;
      step();
      chk("s4_drained_valid", 32'(d_valid), 32'd0);
      chk("s4_drained_in_ready", 32'(d_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("s4_accepted", 32'(d_ready), 32'd0);
      wait_valid("s4b", 17);
      chk_result("s4b", 2, 2'd2);
      drain("s4b");

      // scenario 5: reset in the middle of RUN
      fill(2);
      send("s5");
      for (int k = 0; k < 8; k++) step();
      chk("s5_running", 32'(d_ready), 32'd0);
      rst_n = 1'b0;
      step();
      chk("s5_rst_valid", 32'(d_valid), 32'd0);
      chk("s5_rst_w0", 32'(d_words[0]), 32'd0);
      chk("s5_rst_w1", 32'(d_words[1]), 32'd0);
      chk("s5_rst_w20", 32'(d_words[20]), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("s5_rst_in_ready", 32'(d_ready), 32'd1);
      send("s5b");
      wait_valid("s5b", 17);
      chk_result("s5b", 2, 2'd2);
      drain("s5b");

      // scenario 6: other group sizes on the all-maximum operand
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk("s6_wide_ready", 32'(w_ready), 32'd1);
      chk("s6_narrow_ready", 32'(n_ready), 32'd1);
      fill(2);
      send("s6");
      lat_w = -1;
      lat_n = -1;
      lat_d = -1;
      cw = '0;
      cn = '0;
      for (int k = 0; k < 34; k++) begin
         cap_w[k] = '0;
         cap_n[k] = '0;
      end
      for (int n = 1; n <= 60 && lat_n < 0; n++) begin
         step();
         if (w_valid && lat_w < 0) begin
            lat_w = n;
            cap_w = w_words;
            cw    = w_carry;
         end
         if (n_valid && lat_n < 0) begin
            lat_n = n;
            cap_n = n_words;
            cn    = n_carry;
         end
         if (d_valid && lat_d < 0) lat_d = n;
      end
      chk("s6_wide_latency", 32'(lat_w), 32'd1);
      chk("s6_narrow_latency", 32'(lat_n), 32'd34);
      chk("s6_default_latency", 32'(lat_d), 32'd17);
      for (int i = 0; i < 34; i++) begin
         chk($sformatf("s6_wide_w%0d", i), 32'(cap_w[i]), 32'(exp_word(2, i)));
         chk($sformatf("s6_narrow_w%0d", i), 32'(cap_n[i]), 32'(exp_word(2, i)));
      end
      chk("s6_wide_carry", 32'(cw), 32'd2);
      chk("s6_narrow_carry", 32'(cn), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/limb_carry_normalizer.md
Name: limb_carry_normalizer

Overview:
Sequential carry-propagation stage directly downstream of the redundant-limb multiplier. Captures the multiplier's NUM_LIMBS-limb product, where each limb is BIT_LEN bits with weight 2^(WORD_LEN*i), and ripples carries LIMBS_PER_CYCLE limbs per clock. Emits canonical WORD_LEN-bit words plus the final carry-out. Uses a valid/ready handshake on both sides, so it can sit between the combinational multiplier and a register- or memory-based consumer.

Parameters:
- NUM_LIMBS, 34, limb count of input and output; equals 2*NUM_ELEMENTS of the multiplier.
- BIT_LEN, 17, input limb width.
- WORD_LEN, 16, output word width; limb i has weight 2^(WORD_LEN*i).
- LIMBS_PER_CYCLE, 2, limbs resolved per RUN cycle; must divide NUM_LIMBS.
- CARRY_W, BIT_LEN-WORD_LEN+1, derived carry width; not overridable.

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- rst_n, in, 1, synchronous active-low reset.
- in_valid, in, 1, in_limbs valid.
- in_ready, out, 1, block can accept an operand.
- in_limbs, in, [BIT_LEN-1:0] x NUM_LIMBS, unpacked array of redundant product limbs.
- out_valid, out, 1, out_words/out_carry valid.
- out_ready, in, 1, consumer accepts the result.
- out_words, out, [WORD_LEN-1:0] x NUM_LIMBS, registered canonical words.
- out_carry, out, [CARRY_W-1:0], registered final carry above the top word.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state=IDLE; out_valid=0; out_words all 0; out_carry=0; internal carry=0; group index=0. in_ready=0 while rst_n=0.
- FSM states: IDLE, RUN, DONE.
- in_ready: equals (state==IDLE) && rst_n. This is combinational from state only and does not depend on in_valid.
- IDLE -> RUN: on in_valid&&in_ready.
  - Capture all in_limbs into the working register.
  - Set carry=0 and idx=0.
- RUN, each cycle: process group idx (limbs idx*L .. idx*L+L-1, where L=LIMBS_PER_CYCLE), rippling combinationally within the group.
  - For each limb: s = limb + carry (BIT_LEN+1 bits).
  - word = s[WORD_LEN-1:0]; carry = s >> WORD_LEN.
  - Store each word in place. Register the group's outgoing carry for the next cycle.
- RUN -> DONE: after group idx = NUM_LIMBS/L - 1.
  - Set out_carry = final carry and out_valid=1.
- DONE: out_words, out_carry and out_valid are held stable until out_ready=1. On out_valid&&out_ready -> IDLE with out_valid=0.
- No input/output overlap: a new operand cannot be accepted in the same cycle a result drains. Earliest re-accept is the cycle after drain.
- Latency: G = NUM_LIMBS/L. With the handshake in cycle t, out_valid is first high in cycle t+G+1 (default G=17, so 18 cycles). Throughput is one result per G+2 cycles with out_ready held high.
- Carry bound: limb <= 2^BIT_LEN-1 and carry-in <= 2^(CARRY_W-1), so carry always fits CARRY_W bits and s never overflows BIT_LEN+1 bits.
- in_valid while not in_ready is ignored; in_limbs is not sampled.
- in_limbs changing after capture has no effect.
- rst_n low in any state, including mid-RUN or DONE with out_ready low: the next edge forces the reset values and discards any partial result.
- Elaboration error if NUM_LIMBS % LIMBS_PER_CYCLE != 0 or BIT_LEN <= WORD_LEN.

Decomposition:
- Package limb_norm_pkg contains:
  - FSM state enum {IDLE, RUN, DONE}.
  - Function carry_width(BIT_LEN, WORD_LEN).
  - Function num_groups(NUM_LIMBS, LIMBS_PER_CYCLE).
- Sub-module limb_carry_slice:
  - Combinational ripple of LIMBS_PER_CYCLE limbs.
  - Inputs: limbs and carry_in. Outputs: words and carry_out.
  - Instantiated once. The top holds the FSM, index counter and registers.

Test Plan:
1. All in_limbs=0, out_ready=1 -> out_valid first high 18 cycles after handshake; out_words all 0x0000; out_carry=0; in_ready returns to 1 the cycle after drain.
2. in_limbs[0]=17'h10000, others 0 -> out_words[0]=0x0000, out_words[1]=0x0001, rest 0; out_carry=0.
3. All in_limbs=17'h1FFFF -> out_words[0]=0xFFFF, out_words[1]=0x0000, out_words[2..33]=0x0001; out_carry=2.
4. Backpressure: out_ready=0 for 5 cycles after out_valid, in_valid=1 with new data throughout -> out_valid/out_words/out_carry stable, in_ready=0, new data not captured. When out_ready=1, the drain completes and the next operand is accepted one cycle later.
5. Reset mid-operation: rst_n=0 for one cycle at RUN group 8 -> next cycle state IDLE, out_valid=0, out_words=0, in_ready=1. A following operand from scenario 3 yields the correct result.
6. LIMBS_PER_CYCLE=34 with scenario 3 data -> identical words and carry; out_valid at t+2. LIMBS_PER_CYCLE=1 -> out_valid at t+35.
